uart_pro_rx: RTL and testbench
==============================

# uart_pro_rx

Receive-side protocol parser for the UART test link. Consumes the byte stream from the UART byte receiver, recognises framed host commands, and hands the tester a read request or an 80-bit write payload. It is the inbound counterpart of the protocol transmitter, which frames 80-bit results MSB-byte-first. Malformed or stalled frames are dropped with an error pulse.

## Interface
- PAYLOAD_BYTES, 10, number of payload bytes in a write frame (DATA_OUT width = 8*PAYLOAD_BYTES)
- TIMEOUT_CYC, 9528, idle cycles allowed between bytes inside a frame (about two byte times at the link rate)
- CLK  input  1  system clock
- RST  input  1  reset, synchronous, active-high
- RX_DATA  input  8  received byte; valid only when RX_VALID=1
- RX_VALID  input  1  single-cycle strobe from the byte receiver, one per byte
- DATA_OUT  output  80  last committed write payload; holds value between frames
- START_R  output  1  one-cycle pulse: valid read command received
- START_W  output  1  one-cycle pulse: valid write frame received, DATA_OUT updated the same cycle
- ERR  output  1  one-cycle pulse: frame aborted (bad command, bad terminator, timeout)
- BUSY  output  1  high while a frame is in progress (state != IDLE)

## Operation
- Frame formats:
  - Read: 0x3C, 0x52, 0x3E.
  - Write: 0x3C, 0x57, PAYLOAD_BYTES data bytes, 0x3E.
- States: IDLE, CMD, PAYLOAD, TERM.
- IDLE:
  - 0x3C moves to CMD.
  - Any other byte is ignored silently.
- CMD:
  - 0x52 moves to TERM with the read flag set.
  - 0x57 clears the byte counter and the shadow buffer, then moves to PAYLOAD.
  - Any other byte pulses ERR and returns to IDLE.
- PAYLOAD:
  - Each byte shifts into the shadow buffer: shadow <= {shadow[71:0], RX_DATA}. The first payload byte therefore ends up in [79:72].
  - Any byte value is accepted, including 0x3C and 0x3E.
  - The byte counter is 4 bits. After byte PAYLOAD_BYTES, move to TERM.
- TERM:
  - 0x3E with the read flag set pulses START_R.
  - 0x3E on a write frame copies shadow to DATA_OUT and pulses START_W.
  - Any other byte pulses ERR.
  - All three cases return to IDLE.
- The shadow buffer is never visible on DATA_OUT. DATA_OUT changes only on a committed write frame.
- Reset values: DATA_OUT=0, START_R=0, START_W=0, ERR=0, BUSY=0, state=IDLE, counters=0, shadow=0.
- Reset mid-frame discards the partial frame with no ERR pulse. DATA_OUT returns to 0.

## Timing
- All outputs are registered.
- Latency: RX_VALID with the terminator at cycle t gives START_R/START_W/ERR high for exactly cycle t+1.
- DATA_OUT is valid from t+1 and holds until the next committed write.
- BUSY rises the cycle after the 0x3C byte is accepted. It falls in the same cycle as the completion or ERR pulse.
- Back-to-back frames: a 0x3C arriving the cycle right after a terminator is accepted.
- RX_VALID is assumed to be at most one per cycle. No backpressure is provided.

## Configuration
- UART_PRO_RX_TIMEOUT_EN defined:
  - An inter-byte timeout counter runs whenever state != IDLE. It is 14 bits wide and clears on every RX_VALID.
  - When it reaches TIMEOUT_CYC-1 without a byte: ERR pulses next cycle, the state returns to IDLE, and the shadow is discarded.
  - If RX_VALID coincides with expiry, the byte wins and no timeout occurs.
- UART_PRO_RX_TIMEOUT_EN undefined:
  - No counter is built.
  - A stalled frame waits indefinitely in its current state.
  - ERR only reports command or terminator errors.

## Structure
- Package uart_pro_pkg holds:
  - byte constants SOF=0x3C, EOF=0x3E, CMD_R=0x52, CMD_W=0x57;
  - the state typedef;
  - the default payload length.
  
  The transmitter shares the same package.
- Sub-module uart_pro_rx_timer holds the timeout counter. It has a clear input, an enable input and a one-cycle expire output. It is instantiated only under UART_PRO_RX_TIMEOUT_EN.

## Test plan
- Read frame: 0x3C,0x52,0x3E, one byte every 4764 cycles -> START_R single pulse one cycle after 0x3E; DATA_OUT stays 0; ERR never.
- Write frame: 0x3C,0x57,0x01..0x0A,0x3E -> START_W pulse; DATA_OUT=0x0102030405060708090A; BUSY low after the pulse.
- Bad command: 0x3C,0x41 -> ERR pulse, IDLE. A following valid read frame -> START_R.
- Payload containing 0x3C/0x3E bytes (0x3E repeated 10 times) then 0x3E -> DATA_OUT=0x3E3E3E3E3E3E3E3E3E3E and START_W. Then a write frame whose terminator is replaced by 0x00 -> ERR pulse, DATA_OUT unchanged.
- Timeout (macro on): 0x3C,0x57, three bytes, then silence -> ERR exactly TIMEOUT_CYC cycles after the last RX_VALID. A byte delivered at TIMEOUT_CYC-1 -> no ERR.
- RST asserted after 5 payload bytes -> all outputs 0 next cycle, no ERR. A new full write frame then commits correctly.

Source files
------------

// File: rtl/uart_pro_pkg.sv
// Shared constants and types for the UART test-link protocol (receiver and transmitter).
package uart_pro_pkg;

   localparam logic [7:0] SOF   = 8'h3C;
   localparam logic [7:0] EOF   = 8'h3E;
   localparam logic [7:0] CMD_R = 8'h52;
   localparam logic [7:0] CMD_W = 8'h57;

   localparam int unsigned BYTE_W            = 8;
   localparam int unsigned DEF_PAYLOAD_BYTES = 10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CMD     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_TERM    = 2'd3
   } state_t;

endpackage

// File: rtl/uart_pro_rx_timer.sv
// Inter-byte timeout counter for uart_pro_rx; only built when UART_PRO_RX_TIMEOUT_EN is defined.
module uart_pro_rx_timer
   import uart_pro_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 9528
) (
   input  logic CLK,
   input  logic RST,
   input  logic clr,
   input  logic en,
   output logic expire_c
);

   localparam int unsigned CNT_W = 14;

   logic [CNT_W-1:0] cnt_q;

   // Loading 1 on a byte makes the count equal the number of cycles since that byte.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= CNT_W'(1);
      end else if (!en) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   // A byte arriving in the expiry cycle wins over the timeout.
   assign expire_c = en && !clr && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart_pro_rx.sv
// Receive-side protocol parser: read/write command frames to START_R/START_W/DATA_OUT.
// Optional inter-byte timeout enabled by defining UART_PRO_RX_TIMEOUT_EN.
module uart_pro_rx
   import uart_pro_pkg::*;
#(
   parameter int unsigned PAYLOAD_BYTES = DEF_PAYLOAD_BYTES,
   parameter int unsigned TIMEOUT_CYC   = 9528
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [7:0]                    RX_DATA,
   input  logic                          RX_VALID,
   output logic [8*PAYLOAD_BYTES-1:0]    DATA_OUT,
   output logic                          START_R,
   output logic                          START_W,
   output logic                          ERR,
   output logic                          BUSY
);

   localparam int unsigned DW     = BYTE_W * PAYLOAD_BYTES;
   localparam int unsigned BCNT_W = 4;

   state_t              state_q, state_d;
   logic                rd_q, rd_d;
   logic [BCNT_W-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]       shadow_q, shadow_d;
   logic [DW-1:0]       data_q, data_d;
   logic                start_r_q, start_r_d;
   logic                start_w_q, start_w_d;
   logic                err_q, err_d;
   logic                busy_q, busy_d;
   logic                expire_c;

`ifdef UART_PRO_RX_TIMEOUT_EN
   uart_pro_rx_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timer (
      .CLK      (CLK),
      .RST      (RST),
      .clr      (RX_VALID),
      .en       (state_q != ST_IDLE),
      .expire_c (expire_c)
   );
`else
   logic [13:0] timeout_unused;
   assign timeout_unused = 14'(TIMEOUT_CYC);
   assign expire_c       = 1'b0;
`endif

   // State and datapath registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         rd_q      <= 1'b0;
         cnt_q     <= '0;
         shadow_q  <= '0;
         data_q    <= '0;
         start_r_q <= 1'b0;
         start_w_q <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_q      <= rd_d;
         cnt_q     <= cnt_d;
         shadow_q  <= shadow_d;
         data_q    <= data_d;
         start_r_q <= start_r_d;
         start_w_q <= start_w_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
      end
   end

   // Frame parser: next state and next register values.
   always_comb begin
      state_d   = state_q;
      rd_d      = rd_q;
      cnt_d     = cnt_q;
      shadow_d  = shadow_q;
      data_d    = data_q;
      start_r_d = 1'b0;
      start_w_d = 1'b0;
      err_d     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (RX_VALID && (RX_DATA == SOF)) begin
               state_d = ST_CMD;
            end
         end

         ST_CMD: begin
            if (RX_VALID) begin
               if (RX_DATA == CMD_R) begin
                  rd_d    = 1'b1;
                  state_d = ST_TERM;
               end else if (RX_DATA == CMD_W) begin
                  rd_d     = 1'b0;
                  cnt_d    = '0;
                  shadow_d = '0;
                  state_d  = ST_PAYLOAD;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end

         ST_PAYLOAD: begin
            if (RX_VALID) begin
               shadow_d = {shadow_q[DW-BYTE_W-1:0], RX_DATA};
               cnt_d    = cnt_q + BCNT_W'(1);
               if (cnt_q == BCNT_W'(PAYLOAD_BYTES - 1)) begin
                  state_d = ST_TERM;
               end
            end
         end

         ST_TERM: begin
            if (RX_VALID) begin
               if (RX_DATA == EOF) begin
                  if (rd_q) begin
                     start_r_d = 1'b1;
                  end else begin
                     data_d    = shadow_q;
                     start_w_d = 1'b1;
                  end
               end else begin
                  err_d = 1'b1;
               end
               rd_d    = 1'b0;
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Timeout only fires with no byte present, so it never collides with the cases above.
      if (expire_c) begin
         err_d    = 1'b1;
         rd_d     = 1'b0;
         shadow_d = '0;
         state_d  = ST_IDLE;
      end

      busy_d = (state_d != ST_IDLE);
   end

   assign DATA_OUT = data_q;
   assign START_R  = start_r_q;
   assign START_W  = start_w_q;
   assign ERR      = err_q;
   assign BUSY     = busy_q;

endmodule

// File: tb/tb_uart_pro_rx.sv
// Scoreboard bench for uart_pro_rx: frame-level reference model plus decoupled output monitor.
module tb_uart_pro_rx;
   import uart_pro_pkg::*;

   localparam int unsigned PB = 10;
   localparam int unsigned TC = 9528;
   localparam int unsigned DW = 8 * PB;

   localparam logic [2:0] K_R = 3'b100;
   localparam logic [2:0] K_W = 3'b010;
   localparam logic [2:0] K_E = 3'b001;

   logic          CLK = 1'b0;
   logic          RST;
   logic [7:0]    RX_DATA;
   logic          RX_VALID;
   logic [DW-1:0] DATA_OUT;
   logic          START_R;
   logic          START_W;
   logic          ERR;
   logic          BUSY;

   always #5 CLK = ~CLK;

   uart_pro_rx #(
      .PAYLOAD_BYTES (PB),
      .TIMEOUT_CYC   (TC)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .RX_DATA  (RX_DATA),
      .RX_VALID (RX_VALID),
      .DATA_OUT (DATA_OUT),
      .START_R  (START_R),
      .START_W  (START_W),
      .ERR      (ERR),
      .BUSY     (BUSY)
   );

   typedef struct {
      logic [2:0] kind;
      time        t;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   logic [7:0]    fr[$];
   logic [7:0]    txq[$];
   logic [DW-1:0] model_data;
   bit            model_busy;
   int            idle;
   bit            mon_en;
   logic [2:0]    got;
   int            total;
   int            bad;

   // ---------------- reference model (works on whole collected frames) ----------------
   function automatic void expect_ev(input logic [2:0] k);
      exp_t e;
      e.kind = k;
      e.t    = $time;
      sb.push_back(e);
   endfunction

   function automatic void model_reset();
      fr.delete();
      idle       = 0;
      model_data = '0;
      model_busy = 1'b0;
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      logic [DW-1:0] d;
      d = '0;
      if (fr.size() == 0) begin
         if (b == SOF) fr.push_back(b);
      end else begin
         fr.push_back(b);
         if (fr.size() == 2 && b != CMD_R && b != CMD_W) begin
            expect_ev(K_E);
            fr.delete();
         end else if (fr[1] == CMD_R && fr.size() == 3) begin
            expect_ev((b == EOF) ? K_R : K_E);
            fr.delete();
         end else if (fr[1] == CMD_W && fr.size() == PB + 3) begin
            if (b == EOF) begin
               for (int i = 0; i < PB; i++) d[DW-8-8*i +: 8] = fr[2+i];
               model_data = d;
               expect_ev(K_W);
            end else begin
               expect_ev(K_E);
            end
            fr.delete();
         end
      end
   endfunction

   function automatic void model_edge(input bit v, input logic [7:0] b);
      if (fr.size() > 0 && !v) begin
         idle++;
`ifdef UART_PRO_RX_TIMEOUT_EN
         if (idle == TC - 1) begin
            expect_ev(K_E);
            fr.delete();
         end
`endif
      end
      if (v) begin
         idle = 0;
         model_byte(b);
      end
      model_busy = (fr.size() > 0);
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic step(input bit v, input logic [7:0] b);
      RX_VALID = v;
      RX_DATA  = v ? b : 8'h00;
      @(posedge CLK);
      model_edge(v, b);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      for (int i = 0; i < gap; i++) step(1'b0, 8'h00);
      step(1'b1, b);
   endtask

   task automatic send_txq(input int gap);
      for (int i = 0; i < txq.size(); i++) send(txq[i], gap);
      step(1'b0, 8'h00);
   endtask

   task automatic build_write(input logic [DW-1:0] p, input logic [7:0] term);
      txq.delete();
      txq.push_back(SOF);
      txq.push_back(CMD_W);
      for (int i = 0; i < PB; i++) txq.push_back(p[DW-8-8*i +: 8]);
      txq.push_back(term);
   endtask

   task automatic build_read(input logic [7:0] term);
      txq.delete();
      txq.push_back(SOF);
      txq.push_back(CMD_R);
      txq.push_back(term);
   endtask

   task automatic do_reset();
      RST      = 1'b1;
      RX_VALID = 1'b0;
      @(posedge CLK);
      model_reset();
      #1 RST = 1'b0;
   endtask

   task automatic check_idle_outputs(input string name);
      total++;
      if ({START_R, START_W, ERR, BUSY} !== 4'b0000 || DATA_OUT !== '0) begin
         bad++;
         $display("FAIL %s got r/w/e/busy=%b data=%h need 0000 data=0", name,
                  {START_R, START_W, ERR, BUSY}, DATA_OUT);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge CLK) begin
      if (mon_en) begin
         got = {START_R, START_W, ERR};
         total++;
         if (BUSY !== model_busy) begin
            bad++;
            $display("FAIL busy got=%b need=%b at %0t", BUSY, model_busy, $time);
         end
         total++;
         if (DATA_OUT !== model_data) begin
            bad++;
            $display("FAIL data_out got=%h need=%h at %0t", DATA_OUT, model_data, $time);
         end
         while (sb.size() > 0 && sb[0].t + 5 < $time) begin
            total++;
            bad++;
            $display("FAIL missed_pulse got no pulse need kind=%b at %0t", sb[0].kind, sb[0].t + 5);
            void'(sb.pop_front());
         end
         if (got !== 3'b000) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_pulse got r/w/e=%b at %0t need none", got, $time);
            end else begin
               mon_e = sb.pop_front();
               if (got !== mon_e.kind || $time != mon_e.t + 5) begin
                  bad++;
                  $display("FAIL pulse got r/w/e=%b at %0t need %b at %0t",
                           got, $time, mon_e.kind, mon_e.t + 5);
               end
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      logic [DW-1:0] p;
      logic [7:0]    c;
      int            kind;
      int            gap;
      total    = 0;
      bad      = 0;
      mon_en   = 1'b0;
      RST      = 1'b1;
      RX_VALID = 1'b0;
      RX_DATA  = 8'h00;
      repeat (3) @(posedge CLK);
      model_reset();
      #1 RST = 1'b0;
      check_idle_outputs("reset_state");
      mon_en = 1'b1;

      // Slow read frame.
      build_read(EOF);
      send_txq(4763);

      // Write 01..0A.
      build_write(80'h0102030405060708090A, EOF);
      send_txq(0);

      // Bad command then read.
      txq.delete();
      txq.push_back(SOF);
      txq.push_back(8'h41);
      send_txq(0);
      build_read(EOF);
      send_txq(1);

      // Payload of delimiters, then a bad terminator.
      build_write({PB{EOF}}, EOF);
      send_txq(0);
      build_write(80'h3C3C3E3E3C3E00FF3C3E, 8'h00);
      send_txq(0);

`ifdef UART_PRO_RX_TIMEOUT_EN
      // Timeout after three payload bytes, then a byte landing on the last allowed cycle.
      txq.delete();
      txq.push_back(SOF);
      txq.push_back(CMD_W);
      txq.push_back(8'h11);
      txq.push_back(8'h22);
      txq.push_back(8'h33);
      for (int i = 0; i < txq.size(); i++) send(txq[i], 0);
      repeat (TC + 5) step(1'b0, 8'h00);
      build_write(80'hA1A2A3A4A5A6A7A8A9AA, EOF);
      for (int i = 0; i < txq.size(); i++) send(txq[i], (i == 5) ? TC - 2 : 0);
      step(1'b0, 8'h00);
`else
      // Stalled frame waits indefinitely and still completes.
      build_write(80'hB1B2B3B4B5B6B7B8B9BA, EOF);
      for (int i = 0; i < txq.size(); i++) send(txq[i], (i == 5) ? 12000 : 0);
      step(1'b0, 8'h00);
`endif

      // Reset mid-frame after five payload bytes.
      build_write(80'hC1C2C3C4C5C6C7C8C9CA, EOF);
      for (int i = 0; i < 7; i++) send(txq[i], 0);
      do_reset();
      check_idle_outputs("mid_frame_reset");
      build_write(80'hD1D2D3D4D5D6D7D8D9DA, EOF);
      send_txq(0);

      // Randomized frames, some malformed, with idle garbage between.
      for (int n = 0; n < 60; n++) begin
         kind = int'($urandom_range(0, 4));
         gap  = int'($urandom_range(0, 3));
         case (kind)
            0: begin
               c = ($urandom_range(0, 4) == 0) ? 8'($urandom) : EOF;
               build_read(c);
            end
            1, 2: begin
               for (int i = 0; i < PB; i++) begin
                  case ($urandom_range(0, 5))
                     0:       p[8*i +: 8] = SOF;
                     1:       p[8*i +: 8] = EOF;
                     default: p[8*i +: 8] = 8'($urandom);
                  endcase
               end
               c = ($urandom_range(0, 4) == 0) ? 8'($urandom) : EOF;
               build_write(p, c);
            end
            3: begin
               c = 8'($urandom);
               while (c == CMD_R || c == CMD_W) c = 8'($urandom);
               txq.delete();
               txq.push_back(SOF);
               txq.push_back(c);
            end
            default: begin
               txq.delete();
               txq.push_back(8'($urandom));
            end
         endcase
         send_txq(gap);
      end

      // Close any partial frame left by idle garbage, then drain.
      build_read(EOF);
      send_txq(0);
      repeat (5) step(1'b0, 8'h00);

      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain got %0d pending need 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
